// File: rtl/fpmul_seq_ctrl.sv
// fpmul_seq_ctrl
//   Sequencing controller for a single-precision FP multiplier. It accepts one
//   operand pair over a valid/ready handshake and runs an iterative shift-add
//   24x24 mantissa multiply into a 48-bit product. The product is then
//   normalized, the exponent is adjusted, and the packed result is held for the
//   consumer until it is taken. Only one operation is in flight at a time.
//
//   Optional build macro FPMUL_SPECIAL_EN: when defined, zero/denormal, inf and
//   NaN operands are decoded at accept and the iterative multiply is bypassed.
//   When undefined, exponent fields 0 and 255 are ordinary values.
//
// Parameters
//   RADIX_BITS  multiplier bits retired per MUL cycle (1,2,3,4,6,8,12,24)
//   BIAS        exponent bias
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   operand pair valid
//   in_ready   controller can accept (high only in IDLE)
//   op_a/op_b  IEEE-754 single operands
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     packed product
//   ovf/unf    exponent overflow/underflow, valid with out_valid
//   busy       controller is not idle
//
// State | Meaning
// IDLE  | waiting for an operand pair, in_ready high
// MUL   | retiring RADIX_BITS multiplier bits per cycle into prdt
// NORM  | normalize, adjust exponent, build result (or publish a special result)
// DONE  | result held until out_ready

module fpmul_seq_ctrl #(
  parameter int RADIX_BITS = 1,
  parameter int BIAS       = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        busy
);

  localparam int          ITERS      = 24 / RADIX_BITS;
  localparam logic [4:0]  CNT_LAST   = 5'(ITERS - 1);
  localparam logic [23:0] DIGIT_MASK = 24'((1 << RADIX_BITS) - 1);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t      state;
  logic        sign;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [47:0] ma_sh;   // multiplicand, pre-shifted to the weight of the next digit
  logic [23:0] mb_sh;   // multiplier, consumed LSB first
  logic [47:0] prdt;
  logic [4:0]  cnt;
  logic        spec_hit;
  logic [31:0] spec_res;

  logic [47:0] partial;
  logic        norm_flag;
  logic [22:0] adj_mantissa;
  logic [9:0]  exp_sum;
  logic        exp_ovf;
  logic        exp_unf;
  logic        spec_hit_d;
  logic [31:0] spec_res_d;

  always_comb begin
    partial = ma_sh * {24'b0, mb_sh & DIGIT_MASK};
  end

  // Exponent held as a 10-bit two's-complement value; bit 9 flags negative.
  always_comb begin
    norm_flag    = prdt[47];
    adj_mantissa = norm_flag ? prdt[46:24] : prdt[45:23];
    exp_sum      = {2'b0, ea} + {2'b0, eb} - 10'(BIAS) + {9'b0, norm_flag};
    exp_ovf      = !exp_sum[9] && (exp_sum >= 10'd255);
    exp_unf      = exp_sum[9] || (exp_sum == 10'd0);
  end

`ifdef FPMUL_SPECIAL_EN
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_d;

  always_comb begin
    sign_d     = op_a[31] ^ op_b[31];
    a_zero     = (op_a[30:23] == 8'h00);
    b_zero     = (op_b[30:23] == 8'h00);
    a_inf      = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'b0);
    b_inf      = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'b0);
    a_nan      = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'b0);
    b_nan      = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'b0);
    spec_hit_d = 1'b1;
    spec_res_d = 32'h0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      spec_res_d = 32'h7FC00000;
    else if (a_inf || b_inf)
      spec_res_d = {sign_d, 8'hFF, 23'b0};
    else if (a_zero || b_zero)
      spec_res_d = {sign_d, 31'b0};
    else
      spec_hit_d = 1'b0;
  end
`else
  always_comb begin
    spec_hit_d = 1'b0;
    spec_res_d = 32'h0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= 32'h0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      busy      <= 1'b0;
      sign      <= 1'b0;
      ea        <= 8'h0;
      eb        <= 8'h0;
      ma_sh     <= 48'h0;
      mb_sh     <= 24'h0;
      prdt      <= 48'h0;
      cnt       <= 5'd0;
      spec_hit  <= 1'b0;
      spec_res  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign     <= op_a[31] ^ op_b[31];
            ea       <= op_a[30:23];
            eb       <= op_b[30:23];
            ma_sh    <= {24'b0, 1'b1, op_a[22:0]};
            mb_sh    <= {1'b1, op_b[22:0]};
            prdt     <= 48'h0;
            cnt      <= 5'd0;
            spec_hit <= spec_hit_d;
            spec_res <= spec_res_d;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            // Special operands bypass the multiply; NORM then only publishes.
            state    <= spec_hit_d ? NORM : MUL;
          end
        end
        MUL: begin
          prdt  <= prdt + partial;
          ma_sh <= ma_sh << RADIX_BITS;
          mb_sh <= mb_sh >> RADIX_BITS;
          cnt   <= cnt + 5'd1;
          if (cnt == CNT_LAST)
            state <= NORM;
        end
        NORM: begin
          out_valid <= 1'b1;
          state     <= DONE;
          if (spec_hit) begin
            result <= spec_res;
            ovf    <= 1'b0;
            unf    <= 1'b0;
          end else if (exp_ovf) begin
            result <= {sign, 8'hFF, 23'b0};
            ovf    <= 1'b1;
            unf    <= 1'b0;
          end else if (exp_unf) begin
            result <= {sign, 31'b0};
            ovf    <= 1'b0;
            unf    <= 1'b1;
          end else begin
            result <= {sign, exp_sum[7:0], adj_mantissa};
            ovf    <= 1'b0;
            unf    <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_seq_ctrl.sv
module tb_fpmul_seq_ctrl;

  localparam int R   = 1;
  localparam int LAT = 24 / R + 1;   // edges from accept edge to out_valid

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        unf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpmul_seq_ctrl #(.RADIX_BITS(R), .BIAS(127)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .unf(unf), .busy(busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        o;
    logic        u;
  } vec_t;

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, ovf, unf, busy} !== 5'b10000 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got rdy/vld/ovf/unf/busy=%b result=%h exp 10000 00000000",
               {in_ready, out_valid, ovf, unf, busy}, result);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    vec_t v[6];
    int n;
    v[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    v[1] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0};
    v[2] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0};
    v[3] = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
    v[4] = '{32'hBF800000, 32'h40000000, 32'hC0000000, 1'b0, 1'b0};
    v[5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      start_op(v[i].a, v[i].b);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic%0d_busy got busy=%b in_ready=%b exp 1 0", i, busy, in_ready);
      end
      wait_valid(n);
      checks++;
      if (n != LAT) begin
        errors++;
        $display("FAIL basic%0d_latency got %0d exp %0d", i, n, LAT);
      end
      checks++;
      if (result !== v[i].res || ovf !== v[i].o || unf !== v[i].u) begin
        errors++;
        $display("FAIL basic%0d_result got %h ovf=%b unf=%b exp %h ovf=%b unf=%b",
                 i, result, ovf, unf, v[i].res, v[i].o, v[i].u);
      end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL basic%0d_release got vld=%b rdy=%b ovf=%b unf=%b busy=%b exp 0 1 0 0 0",
                 i, out_valid, in_ready, ovf, unf, busy);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    start_op(32'h3FC00000, 32'h40000000);
    // New operands and in_valid during MUL/DONE must not disturb the operation.
    op_a = 32'h7F000000;
    op_b = 32'h7F000000;
    in_valid = 1'b1;
    wait_valid(n);
    checks++;
    if (n != LAT || result !== 32'h40400000) begin
      errors++;
      $display("FAIL bp_first got n=%0d result=%h exp n=%0d 40400000", n, result, LAT);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h40400000 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b rdy=%b result=%h ovf=%b exp 1 0 40400000 0",
                 i, out_valid, in_ready, result, ovf);
      end
    end
    handshake();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
    end
    // in_valid still high: accepted on this edge.
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept got busy=%b rdy=%b exp 1 0", busy, in_ready);
    end
    wait_valid(n);
    checks++;
    if (n != LAT || result !== 32'h7F800000 || ovf !== 1'b1 || unf !== 1'b0) begin
      errors++;
      $display("FAIL bp_second got n=%0d result=%h ovf=%b unf=%b exp n=%0d 7F800000 1 0",
               n, result, ovf, unf, LAT);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    handshake();
    start_op(32'h40000000, 32'h40000000);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, ovf, unf, busy} !== 5'b10000 || result !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset got rdy/vld/ovf/unf/busy=%b result=%h exp 10000 00000000",
               {in_ready, out_valid, ovf, unf, busy}, result);
    end
    start_op(32'h3F800000, 32'h3F800000);
    wait_valid(n);
    checks++;
    if (n != LAT || result !== 32'h3F800000 || ovf !== 1'b0 || unf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_fresh got n=%0d result=%h ovf=%b unf=%b exp n=%0d 3F800000 0 0",
               n, result, ovf, unf, LAT);
    end
    handshake();
  endtask

  task automatic test_special();
    vec_t v[2];
    int lat_exp;
    int n;
`ifdef FPMUL_SPECIAL_EN
    lat_exp = 1;
    v[0] = '{32'h00000000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0};
    v[1] = '{32'h7FC00000, 32'h40000000, 32'h7FC00000, 1'b0, 1'b0};
`else
    lat_exp = LAT;
    v[0] = '{32'h00000000, 32'h3F800000, 32'h00000000, 1'b0, 1'b1};
    v[1] = '{32'h7FC00000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 2; i++) begin
      start_op(v[i].a, v[i].b);
      wait_valid(n);
      checks++;
      if (n != lat_exp) begin
        errors++;
        $display("FAIL special%0d_latency got %0d exp %0d", i, n, lat_exp);
      end
      checks++;
      if (result !== v[i].res || ovf !== v[i].o || unf !== v[i].u) begin
        errors++;
        $display("FAIL special%0d_result got %h ovf=%b unf=%b exp %h ovf=%b unf=%b",
                 i, result, ovf, unf, v[i].res, v[i].o, v[i].u);
      end
      handshake();
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = 32'h0;
    op_b = 32'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_special();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
